// File: rtl/rv32i_types.sv
// rv32i_types: shared RV32I decode, ROB bus and ACU reservation-station types
package rv32i_types;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011
    } rv32i_opcode;

    typedef struct packed {
        logic [3:0]  tag;
        logic        rdy;
        logic [31:0] data;
    } sal_t;

    typedef struct packed {
        rv32i_opcode opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] pc;
        logic [31:0] i_imm;
        logic [31:0] u_imm;
    } pci_t;

    typedef enum logic [3:0] {
        alu_add, alu_sub, alu_sll, alu_slt, alu_sltu,
        alu_xor, alu_srl, alu_sra, alu_or, alu_and
    } alu_op_t;

    typedef struct packed {
        logic        valid;
        alu_op_t     op;
        logic [3:0]  tag;
        logic        s1_rdy;
        logic [3:0]  s1_tag;
        logic [31:0] s1_data;
        logic        s2_rdy;
        logic [3:0]  s2_tag;
        logic [31:0] s2_data;
    } acu_rs_entry_t;

    // funct7[5] (alt) picks sub/sra; op_imm never subtracts, auipc always adds
    function automatic alu_op_t decode_alu_op(input rv32i_opcode opc, input logic [2:0] f3, input logic alt);
        if (opc == op_auipc) return alu_add;
        case (f3)
            3'b000:  return (opc == op_reg && alt) ? alu_sub : alu_add;
            3'b001:  return alu_sll;
            3'b010:  return alu_slt;
            3'b011:  return alu_sltu;
            3'b100:  return alu_xor;
            3'b101:  return alt ? alu_sra : alu_srl;
            3'b110:  return alu_or;
            default: return alu_and;
        endcase
    endfunction

endpackage

// File: rtl/acu_alu.sv
// acu_alu: combinational RV32I integer ALU for the ACU reservation station
module acu_alu
    import rv32i_types::*;
#(
    parameter int width = 32
) (
    input  alu_op_t           op_i,
    input  logic [width-1:0]  a_i,
    input  logic [width-1:0]  b_i,
    output logic [width-1:0]  y_o
);

    logic [4:0]              sh;
    logic signed [width-1:0] as;
    logic signed [width-1:0] bs;

    assign sh = b_i[4:0];
    assign as = a_i;
    assign bs = b_i;

    // result mux, all arithmetic wraps modulo 2^width
    always_comb begin
        case (op_i)
            alu_add:  y_o = a_i + b_i;
            alu_sub:  y_o = a_i - b_i;
            alu_sll:  y_o = a_i << sh;
            alu_slt:  y_o = {{(width-1){1'b0}}, as < bs};
            alu_sltu: y_o = {{(width-1){1'b0}}, a_i < b_i};
            alu_xor:  y_o = a_i ^ b_i;
            alu_srl:  y_o = a_i >> sh;
            alu_sra:  y_o = as >>> sh;
            alu_or:   y_o = a_i | b_i;
            alu_and:  y_o = a_i & b_i;
            default:  y_o = '0;
        endcase
    end

endmodule

// File: rtl/acu_reservation_station.sv
// acu_reservation_station: holds ALU ops until operands resolve, issues one per cycle to the ROB
module acu_reservation_station
    import rv32i_types::*;
#(
    parameter int size     = 8,
    parameter int rob_size = 8,
    parameter int width    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  pci_t                  pci,
    input  logic [3:0]            rd_tag,
    input  sal_t                  src1,
    input  sal_t                  src2,
    input  sal_t [rob_size-1:0]   rob_broadcast_bus,
    output logic                  stall,
    output sal_t [size-1:0]       acu_rs_o
);

    localparam int IW = $clog2(size);
    localparam int CW = IW + 1;

    acu_rs_entry_t [size-1:0] entries_q, entries_d;
    sal_t [size-1:0]          acu_rs_q, acu_rs_d;
    acu_rs_entry_t            new_e;
    logic [15:0]              bus_hit;
    logic [width-1:0]         bus_dat [16];
    logic [CW-1:0]            cnt;
    logic [IW-1:0]            free_idx, iss_idx;
    logic                     has_iss, alloc;
    logic [width-1:0]         alu_y;
    logic                     unused;

    assign unused = ^{pci.funct7[6], pci.funct7[4:0], rob_broadcast_bus};

    // ROB bus viewed as a 16-entry tag lookup; tags beyond rob_size never hit
    always_comb begin
        bus_hit = '0;
        for (int t = 0; t < 16; t++) bus_dat[t] = '0;
        for (int t = 0; t < rob_size; t++) begin
            bus_hit[t] = rob_broadcast_bus[t].rdy;
            bus_dat[t] = rob_broadcast_bus[t].data;
        end
    end

    // occupancy count, lowest free slot and lowest issuable slot from current state
    always_comb begin
        cnt      = '0;
        free_idx = '0;
        iss_idx  = '0;
        has_iss  = 1'b0;
        for (int i = size - 1; i >= 0; i--) begin
            cnt = cnt + CW'(entries_q[i].valid);
            if (!entries_q[i].valid) free_idx = IW'(i);
            if (entries_q[i].valid && entries_q[i].s1_rdy && entries_q[i].s2_rdy) begin
                iss_idx = IW'(i);
                has_iss = 1'b1;
            end
        end
    end

    assign stall = cnt == CW'(size);
    assign alloc = load && !stall && (pci.opcode inside {op_imm, op_reg, op_auipc});

    // incoming entry: auipc/imm fold pc and immediates into the operand slots
    always_comb begin
        new_e         = '0;
        new_e.valid   = 1'b1;
        new_e.op      = decode_alu_op(pci.opcode, pci.funct3, pci.funct7[5]);
        new_e.tag     = rd_tag;
        new_e.s1_tag  = src1.tag;
        new_e.s1_rdy  = pci.opcode == op_auipc || src1.rdy || bus_hit[src1.tag];
        new_e.s1_data = pci.opcode == op_auipc ? pci.pc : src1.rdy ? src1.data : bus_dat[src1.tag];
        new_e.s2_tag  = src2.tag;
        new_e.s2_rdy  = pci.opcode != op_reg || src2.rdy || bus_hit[src2.tag];
        new_e.s2_data = pci.opcode == op_auipc ? pci.u_imm : pci.opcode == op_imm ? pci.i_imm :
                        src2.rdy ? src2.data : bus_dat[src2.tag];
    end

    // snoop waiting operands, retire the issued entry, allocate into a pre-edge free slot
    always_comb begin
        entries_d = entries_q;
        for (int i = 0; i < size; i++) begin
            if (!entries_q[i].s1_rdy && bus_hit[entries_q[i].s1_tag]) begin
                entries_d[i].s1_rdy  = 1'b1;
                entries_d[i].s1_data = bus_dat[entries_q[i].s1_tag];
            end
            if (!entries_q[i].s2_rdy && bus_hit[entries_q[i].s2_tag]) begin
                entries_d[i].s2_rdy  = 1'b1;
                entries_d[i].s2_data = bus_dat[entries_q[i].s2_tag];
            end
        end
        if (has_iss) entries_d[iss_idx].valid = 1'b0;
        if (alloc) entries_d[free_idx] = new_e;
    end

    acu_alu #(.width(width)) u_alu (
        .op_i (entries_q[iss_idx].op),
        .a_i  (entries_q[iss_idx].s1_data),
        .b_i  (entries_q[iss_idx].s2_data),
        .y_o  (alu_y)
    );

    // completion slots hold a result for exactly one cycle
    always_comb begin
        acu_rs_d = '0;
        if (has_iss) acu_rs_d[iss_idx] = '{tag: entries_q[iss_idx].tag, rdy: 1'b1, data: alu_y};
    end

    // state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries_q <= '0;
            acu_rs_q  <= '0;
        end else begin
            entries_q <= entries_d;
            acu_rs_q  <= acu_rs_d;
        end
    end

    assign acu_rs_o = acu_rs_q;

endmodule

// File: doc/acu_reservation_station.md
Name: acu_reservation_station

Overview:
- Arithmetic reservation station on the far side of the reorder buffer's ACU interface.
- Accepts op_imm / op_reg / op_auipc instructions when the ROB pulses load_acu_rs.
- Holds operands until they are ready, snooping the ROB broadcast bus for missing values.
- Executes one ready entry per cycle on an internal ALU and returns the tagged result to the ROB on per-slot completion outputs (sal_t: tag[3:0], rdy, data[31:0]).

Parameters:
- size, 8, number of RS entries; also the length of acu_rs_o.
- rob_size, 8, length of the rob_broadcast_bus input.
- width, 32, data width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load  input  1  allocate an entry this cycle (driven by the ROB's load_acu_rs).
- pci  input  pci_t  decoded instruction; fields used: opcode, funct3, funct7, pc, i_imm, u_imm.
- rd_tag  input  4  ROB tag of the instruction being loaded.
- src1  input  sal_t  rs1 operand: rdy=1 means data is valid; otherwise tag names the producing ROB entry.
- src2  input  sal_t  rs2 operand, same encoding; used only for op_reg.
- rob_broadcast_bus  input  sal_t[rob_size]  ROB result bus, indexed by tag, valid when .rdy.
- stall  output  1  all entries occupied.
- acu_rs_o  output  sal_t[size]  per-slot completion; .rdy pulses for one cycle with tag and result.

Behaviour:
- Reset (async, rst_n=0): all entries invalid; every acu_rs_o slot is all-zero; stall=0. Reset asserted mid-operation discards all entries and results, with no partial completions.
- Entry state: valid, issued, opcode/funct3/funct7, pc, imm, tag; per operand a rdy flag, tag and data.
- stall = (number of valid entries == size). It is combinational on current state only and ignores a same-cycle issue.
- Load while stall=1 is ignored: no allocation, no state change.
- Allocation: on the edge where load=1, write the lowest-index invalid entry.
- Operand capture at allocation, per operand:
  - if src.rdy, take src.data;
  - else if rob_broadcast_bus[src.tag].rdy, take that bus data (bypass);
  - else store the tag and mark the operand waiting.
- Operands forced ready at allocation: src2 for op_imm and op_auipc; src1 for op_auipc.
- Snoop: on each edge, every waiting operand with rob_broadcast_bus[tag].rdy=1 captures .data and becomes ready. Multiple entries may capture from the same bus slot on the same edge.
- Issue selection: the lowest-index valid entry whose operands were both ready at the start of the cycle. At most one issue per cycle.
- Issue edge: the ALU result is registered into acu_rs_o[idx] as {tag, rdy=1, data}, and the entry is invalidated on the same edge.
- Completion pulse: acu_rs_o[idx].rdy is high for exactly one cycle. On the following edge the slot clears to zero unless a new issue from the same slot overwrites it.
- Latency: an entry loaded with both operands ready at edge E0 issues at E1; acu_rs_o rdy is visible for the cycle after E1. A slot freed at edge E is reusable by a load at E+1.
- ALU operations (32-bit, modulo 2^32):
  - op_reg (A=src1, B=src2): add/sub selected by funct7[5]; sll, slt (signed), sltu, xor, srl/sra selected by funct7[5], or, and. Shift amount is B[4:0].
  - op_imm: same functions with B = i_imm; no sub; srai selected by funct7[5].
  - op_auipc: pc + u_imm.
- Unsupported opcode on load: entry not allocated.
- Simultaneous load and issue: both occur. The allocation picks from entries invalid before the edge, so it never takes the slot being freed.
- Simultaneous load and broadcast of the needed tag: the bypass rule gives a ready operand at allocation.

Decomposition:
- rv32i_types (shared package): sal_t, pci_t and the opcode enum already live here; add acu_rs_entry_t (entry struct) and an alu_op_t enum.
- Sub-module acu_alu: combinational; inputs alu_op_t, A and B; output 32-bit result. Instantiated once.
- The RS owns decode (opcode/funct3/funct7 to alu_op_t), allocation, snoop, select and the output registers.

Test Plan:
- Reset: rst_n low mid-run with 3 valid entries -> stall=0, all acu_rs_o zero, no rdy pulse after release.
- Ready op: op_imm addi, src1={rdy=1,data=5}, imm=-7, rd_tag=3 -> exactly two edges later acu_rs_o[0]={tag=3,rdy=1,data=32'hFFFFFFFE}, high one cycle.
- Dependency: op_reg sub, src1 ready=10, src2 waiting on tag 2; broadcast bus[2]={rdy=1,data=3} three cycles later -> result 7 with rd_tag, one cycle after capture.
- Bypass: load with src1 waiting on tag 5 while bus[5].rdy=1, data=0x80000000, op srai 4 -> result 0xF8000000.
- Full/stall: 8 loads with unresolved src1 -> stall=1; ninth load ignored; broadcast resolves all 8 -> issues in index order 0..7, one per cycle, stall drops after the first issue.
- AUIPC and signed ops: auipc pc=0x1000, u_imm=0x2000 -> 0x3000; slt(-1,1)=1; sltu(-1,1)=0.
